// File: rtl/hv_dispatch.sv
// hv_dispatch: assembles narrow DMA beats into full DIM+1-bit hypervectors
// and hands each one to a compute core, round-robin, via valid/ready with a
// one-hot core select.
// Optional build macro: HV_DISPATCH_BCAST_EN adds a `bcast` input that sends
// a vector to all cores at once (handoff waits for every core to be ready).
module hv_dispatch #(
  parameter int DIM     = 1023,
  parameter int CORENUM = 12,
  parameter int BUSW    = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               src_v,
  input  logic [BUSW-1:0]    src_d,
  input  logic               src_last,
  output logic               src_ready,
  input  logic [CORENUM-1:0] core_ready,
  output logic [DIM:0]       hv_d,
  output logic               hv_v,
  output logic [CORENUM-1:0] hv_sel,
`ifdef HV_DISPATCH_BCAST_EN
  output logic               load_done,
  input  logic               bcast
`else
  output logic               load_done
`endif
);

  localparam int BEATS = (DIM + 1) / BUSW;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = (CORENUM > 1) ? $clog2(CORENUM) : 1;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [BW-1:0]      r_beat;
  logic [PW-1:0]      r_ptr;
  logic               r_last_pend;
  logic [DIM:0]       r_hv_d;
  logic               r_hv_v;
  logic [CORENUM-1:0] r_hv_sel;
  logic               r_load_done;

  logic [DIM:0]       w_hv_fill;
  logic [CORENUM-1:0] w_sel_onehot;
  logic               w_src_ready;
  logic               w_accept;
  logic               w_final_beat;
  logic               w_vec_end;
  logic               w_ptr_hit;
  logic               w_handoff;
  logic               w_bcast_in;
  logic               w_bcast;

`ifdef HV_DISPATCH_BCAST_EN
  logic               r_bcast;

  assign w_bcast_in = bcast;
  assign w_bcast    = r_bcast;
`else
  assign w_bcast_in = 1'b0;
  assign w_bcast    = 1'b0;
`endif

  assign w_sel_onehot = CORENUM'(1) << r_ptr;
  assign w_ptr_hit    = |(core_ready & w_sel_onehot);
  assign w_final_beat = (r_beat == BW'(BEATS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: FILL until the vector ends, ISSUE until the target core takes it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL: begin
        if (w_accept && w_vec_end) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (w_handoff) begin
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // Output/handshake decode; src_ready depends only on registered state and rst
  always_comb begin
    w_src_ready = 1'b0;
    w_accept    = 1'b0;
    w_vec_end   = 1'b0;
    w_handoff   = 1'b0;
    if (!rst && (r_state == FILL)) begin
      w_src_ready = 1'b1;
    end
    w_accept  = src_v && w_src_ready;
    w_vec_end = w_final_beat || src_last;
    if (r_state == ISSUE) begin
      w_handoff = w_bcast ? (&core_ready) : w_ptr_hit;
    end
  end

  // Beat insertion: current beat lands in its slice; an early src_last
  // clears every slice above it in the same write
  always_comb begin
    w_hv_fill = r_hv_d;
    for (int unsigned j = 0; j < BEATS; j++) begin
      if (j == 32'(r_beat)) begin
        w_hv_fill[j*BUSW +: BUSW] = src_d;
      end else if (src_last && (j > 32'(r_beat))) begin
        w_hv_fill[j*BUSW +: BUSW] = '0;
      end
    end
  end

  // Datapath, core pointer, transfer tracking and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat      <= '0;
      r_ptr       <= '0;
      r_last_pend <= 1'b0;
      r_hv_d      <= '0;
      r_hv_v      <= 1'b0;
      r_hv_sel    <= '0;
      r_load_done <= 1'b0;
`ifdef HV_DISPATCH_BCAST_EN
      r_bcast     <= 1'b0;
`endif
    end else begin
      r_load_done <= w_handoff && r_last_pend;

      if (w_accept) begin
        r_hv_d <= w_hv_fill;
        r_beat <= w_vec_end ? '0 : r_beat + 1'b1;
        if (src_last) begin
          r_last_pend <= 1'b1;
        end
        if (w_vec_end) begin
          r_hv_v   <= 1'b1;
          r_hv_sel <= w_bcast_in ? '1 : w_sel_onehot;
`ifdef HV_DISPATCH_BCAST_EN
          r_bcast  <= bcast;
`endif
        end
      end

      if (w_handoff) begin
        r_hv_v   <= 1'b0;
        r_hv_sel <= '0;
        r_beat   <= '0;
        // End of transfer restarts the rotation at core 0, even after a broadcast
        if (r_last_pend) begin
          r_ptr       <= '0;
          r_last_pend <= 1'b0;
        end else if (!w_bcast) begin
          r_ptr <= (r_ptr == PW'(CORENUM - 1)) ? '0 : r_ptr + 1'b1;
        end
      end
    end
  end

  assign src_ready = w_src_ready;
  assign hv_d      = r_hv_d;
  assign hv_v      = r_hv_v;
  assign hv_sel    = r_hv_sel;
  assign load_done = r_load_done;

endmodule

// File: tb/tb_hv_dispatch.sv
// Directed testbench for hv_dispatch: reset values, beat ordering, round-robin
// wrap, backpressure, short final vector with load_done, reset mid-fill.
module tb_hv_dispatch;

  localparam int DIM     = 1023;
  localparam int CORENUM = 12;
  localparam int BUSW    = 64;
  localparam int BEATS   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               src_v;
  logic [BUSW-1:0]    src_d;
  logic               src_last;
  logic               src_ready;
  logic [CORENUM-1:0] core_ready;
  logic [DIM:0]       hv_d;
  logic               hv_v;
  logic [CORENUM-1:0] hv_sel;
  logic               load_done;
`ifdef HV_DISPATCH_BCAST_EN
  logic               bcast = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hv_dispatch #(
    .DIM     (DIM),
    .CORENUM (CORENUM),
    .BUSW    (BUSW)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .src_v      (src_v),
    .src_d      (src_d),
    .src_last   (src_last),
    .src_ready  (src_ready),
    .core_ready (core_ready),
    .hv_d       (hv_d),
    .hv_v       (hv_v),
    .hv_sel     (hv_sel),
`ifdef HV_DISPATCH_BCAST_EN
    .load_done  (load_done),
    .bcast      (bcast)
`else
    .load_done  (load_done)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted beat; idle cycles present junk data and a stray src_last
  task automatic beat(input logic [63:0] d, input bit last);
    src_v    = 1'b1;
    src_d    = d;
    src_last = last;
    chk("src_ready_fill", 64'(src_ready), 64'd1);
    tick();
    src_v    = 1'b0;
    src_d    = 64'hBADC_0FFE_E0DD_F00D;
    src_last = 1'b1;
  endtask

  task automatic send_vec(input logic [63:0] base, input int nb, input bit last);
    for (int k = 0; k < nb; k++) begin
      if (k > 0) chk("hv_v_fill", 64'(hv_v), 64'd0);
      beat(base + 64'(k), last && (k == nb - 1));
    end
  endtask

  task automatic chk_issue(input logic [11:0] sel, input logic [63:0] base, input int nb);
    chk("hv_v_issue", 64'(hv_v), 64'd1);
    chk("hv_sel", 64'(hv_sel), 64'(sel));
    chk("src_ready_issue", 64'(src_ready), 64'd0);
    for (int k = 0; k < BEATS; k++) begin
      chk($sformatf("hv_d[%0d]", k), hv_d[k*64 +: 64], (k < nb) ? base + 64'(k) : 64'd0);
    end
  endtask

  task automatic handoff(input bit ld);
    tick();
    chk("hv_v_after", 64'(hv_v), 64'd0);
    chk("src_ready_after", 64'(src_ready), 64'd1);
    chk("load_done", 64'(load_done), 64'(ld));
  endtask

  initial begin
    logic [DIM:0]  saved;
    logic [11:0]   esel;

    rst        = 1'b1;
    src_v      = 1'b0;
    src_d      = '0;
    src_last   = 1'b0;
    core_ready = '1;

    // Reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hv_v", 64'(hv_v), 64'd0);
      chk("rst_hv_sel", 64'(hv_sel), 64'd0);
      chk("rst_load_done", 64'(load_done), 64'd0);
      chk("rst_src_ready", 64'(src_ready), 64'd0);
      chk("rst_hv_d_zero", 64'(|hv_d), 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("src_ready_release", 64'(src_ready), 64'd1);

    // Beat ordering: beat k carries k
    send_vec(64'd0, 16, 1'b0);
    chk_issue(12'h001, 64'd0, 16);
    handoff(1'b0);

    // Round-robin through all cores and back to core 0
    for (int i = 1; i <= 12; i++) begin
      esel = 12'h001 << (i % 12);
      send_vec(64'(i) << 32, 16, 1'b0);
      chk_issue(esel, 64'(i) << 32, 16);
      handoff(1'b0);
    end

    // Reset between vectors returns the pointer to core 0
    rst = 1'b1;
    #1;
    chk("src_ready_in_rst", 64'(src_ready), 64'd0);
    tick();
    chk("rst2_hv_v", 64'(hv_v), 64'd0);
    rst = 1'b0;
    #1;

    // Short final vector: full vector to core 0, 4-beat vector to core 1
    send_vec(64'h1111_0000_0000_0000, 16, 1'b0);
    chk_issue(12'h001, 64'h1111_0000_0000_0000, 16);
    handoff(1'b0);
    send_vec(64'h2222_0000_0000_0000, 4, 1'b1);
    chk_issue(12'h002, 64'h2222_0000_0000_0000, 4);
    handoff(1'b1);
    tick();
    chk("load_done_once", 64'(load_done), 64'd0);
    chk("src_ready_idle", 64'(src_ready), 64'd1);

    // Backpressure on core 0 for 20 cycles; next transfer restarts at core 0
    core_ready = 12'hFFE;
    send_vec(64'h3333_0000_0000_0000, 16, 1'b0);
    chk_issue(12'h001, 64'h3333_0000_0000_0000, 16);
    saved = hv_d;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_hv_v", 64'(hv_v), 64'd1);
      chk("bp_src_ready", 64'(src_ready), 64'd0);
      chk("bp_hv_sel", 64'(hv_sel), 64'h001);
      chk("bp_hv_d_stable", 64'(hv_d == saved), 64'd1);
    end
    core_ready = '1;
    handoff(1'b0);

    // Reset after 7 beats discards the partial vector
    send_vec(64'h4444_0000_0000_0000, 7, 1'b0);
    chk("partial_hv_v", 64'(hv_v), 64'd0);
    rst = 1'b1;
    tick();
    chk("midfill_hv_v", 64'(hv_v), 64'd0);
    chk("midfill_hv_d_zero", 64'(|hv_d), 64'd0);
    rst = 1'b0;
    #1;
    send_vec(64'h5555_0000_0000_0000, 16, 1'b0);
    chk_issue(12'h001, 64'h5555_0000_0000_0000, 16);
    handoff(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
